// File: rtl/wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// wb_stage_pkg
// Shared definitions for the write-back stage:
//   - register-file write strobe polarity (WRITE / READ)
//   - GPR data width and register count
//   - load funct3 codes (LB, LH, LW, LBU, LHU)
//   - write-back FSM state encoding
// Optional feature macro used by the stage: WB_MISALIGN_TRAP_EN.
// ----------------------------------------------------------------------------
package wb_stage_pkg;

    // gpr_we_ is active low: WRITE strobes the register file, READ idles it.
    localparam logic WRITE = 1'b0;
    localparam logic READ  = 1'b1;

    localparam int DATA_WIDTH_GPR = 32;
    localparam int DATA_HIGH_GPR  = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// ----------------------------------------------------------------------------
// wb_stage_if
// Bundles the MEM-stage handshake, data-bus return path and register-file
// write port of the write-back stage.
//   flush          pipeline kill, synchronous
//   mem_*          instruction presented by MEM (valid/rd_en/rd_addr/is_load/
//                  load_type/result)
//   dbus_rvalid/rdata  load return data, one-cycle pulse
//   wb_stall       stage busy, MEM holds its instruction
//   gpr_we_/gpr_wr_addr/gpr_wr_data  register-file write port (we_ active low)
//
// Handshake: MEM presents mem_valid with its payload; the instruction is taken
// on a rising edge where mem_valid=1, wb_stall=0 and flush=0. While wb_stall=1
// MEM keeps mem_valid and payload stable. dbus_rvalid is a single-cycle pulse
// with no backpressure and is only meaningful while a load is outstanding.
//
// Modports: master = pipeline/bus side driving the stage, slave = wb_stage.
// ----------------------------------------------------------------------------
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              flush;
    logic              mem_valid;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_is_load;
    logic [2:0]        mem_load_type;
    logic [DATA_W-1:0] mem_result;
    logic              dbus_rvalid;
    logic [DATA_W-1:0] dbus_rdata;
    logic              wb_stall;
    logic              gpr_we_;
    logic [ADDR_W-1:0] gpr_wr_addr;
    logic [DATA_W-1:0] gpr_wr_data;

    modport master (
        output flush, mem_valid, mem_rd_en, mem_rd_addr, mem_is_load,
               mem_load_type, mem_result, dbus_rvalid, dbus_rdata,
        input  wb_stall, gpr_we_, gpr_wr_addr, gpr_wr_data
    );

    modport slave (
        input  flush, mem_valid, mem_rd_en, mem_rd_addr, mem_is_load,
               mem_load_type, mem_result, dbus_rvalid, dbus_rdata,
        output wb_stall, gpr_we_, gpr_wr_addr, gpr_wr_data
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Purely combinational load data formatter. Selects the byte/half lane of a
// naturally aligned 32-bit bus word and sign- or zero-extends it.
//   i_load_type   load funct3
//   i_addr_lo     effective address bits [1:0]
//   i_rdata       bus read word
//   o_data        aligned/extended result
//   o_valid_type  funct3 is one of LB/LH/LW/LBU/LHU
//   o_misaligned  LH/LHU at odd address, or LW not word aligned
// Lane selection ignores the offending low bits (half lane = addr[1], LW =
// whole word); the caller decides whether o_misaligned matters.
// ----------------------------------------------------------------------------
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH_GPR
) (
    input  logic [2:0]        i_load_type,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid_type,
    output logic              o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane pick assumes a 32-bit bus word.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data       = '0;
        o_valid_type = 1'b1;
        o_misaligned = 1'b0;
        case (i_load_type)
            LB:  o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LBU: o_data = {{(DATA_W-8){1'b0}}, w_byte};
            LH: begin
                o_data       = {{(DATA_W-16){w_half[15]}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            LHU: begin
                o_data       = {{(DATA_W-16){1'b0}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            LW: begin
                o_data       = i_rdata;
                o_misaligned = |i_addr_lo;
            end
            default: o_valid_type = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
// Write-back stage feeding the single GPR write port. ALU results are written
// the cycle after acceptance; loads park the stage in WAIT_LOAD (wb_stall=1)
// until dbus_rvalid, then the aligned data is written the following cycle.
// Writes to x0, writes with rd_en=0 and reserved load types are suppressed.
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   bus             wb_stage_if.slave (MEM handshake, dbus return, GPR port)
//   load_misaligned (only with WB_MISALIGN_TRAP_EN) one-cycle trap pulse
//   dbg_state       current FSM state, for observation only
// Optional feature macro: WB_MISALIGN_TRAP_EN -- misaligned LH/LHU/LW loads
// raise load_misaligned and do not write.
// ----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH_GPR,
    parameter int ADDR_W = $clog2(DATA_HIGH_GPR)
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus,
`ifdef WB_MISALIGN_TRAP_EN
    output logic       load_misaligned,
`endif
    output wb_state_e  dbg_state
);

    wb_state_e         r_state;
    wb_state_e         w_state_nxt;

    // Fields of the outstanding load.
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [2:0]        r_load_type;
    logic [1:0]        r_addr_lo;

    logic              r_gpr_we_;
    logic [ADDR_W-1:0] r_gpr_wr_addr;
    logic [DATA_W-1:0] r_gpr_wr_data;

    logic              w_stall;
    logic              w_accept;
    logic              w_load_done;
    logic              w_wr_fire;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    logic [DATA_W-1:0] w_align_data;
    logic              w_align_valid_type;
    logic              w_align_misaligned;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .i_load_type  (r_load_type),
        .i_addr_lo    (r_addr_lo),
        .i_rdata      (bus.dbus_rdata),
        .o_data       (w_align_data),
        .o_valid_type (w_align_valid_type),
        .o_misaligned (w_align_misaligned)
    );

    // Stall is a decode of the state register only, so MEM never sees a
    // combinational path from stage inputs.
    assign w_stall     = (r_state == WB_WAIT_LOAD);
    assign w_accept    = bus.mem_valid && !w_stall && !bus.flush;
    // rvalid only counts while waiting; a pulse in the acceptance cycle lands
    // while still IDLE and is therefore ignored.
    assign w_load_done = w_stall && bus.dbus_rvalid && !bus.flush;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = WB_IDLE;
        end else begin
            case (r_state)
                WB_IDLE:      if (w_accept && bus.mem_is_load) w_state_nxt = WB_WAIT_LOAD;
                WB_WAIT_LOAD: if (bus.dbus_rvalid)             w_state_nxt = WB_IDLE;
                default:      w_state_nxt = WB_IDLE;
            endcase
        end
    end

    // Write selection. Acceptance only happens in IDLE and completion only in
    // WAIT_LOAD, so at most one source is active per cycle.
    always_comb begin
        w_wr_fire = 1'b0;
        w_wr_addr = r_gpr_wr_addr;
        w_wr_data = r_gpr_wr_data;
        if (w_accept && !bus.mem_is_load) begin
            w_wr_fire = bus.mem_rd_en && (bus.mem_rd_addr != '0);
            w_wr_addr = bus.mem_rd_addr;
            w_wr_data = bus.mem_result;
        end else if (w_load_done) begin
            w_wr_fire = r_rd_en && (r_rd_addr != '0) && w_align_valid_type
`ifdef WB_MISALIGN_TRAP_EN
                        && !w_align_misaligned
`endif
                        ;
            w_wr_addr = r_rd_addr;
            w_wr_data = w_align_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= WB_IDLE;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_load_type   <= '0;
            r_addr_lo     <= '0;
            r_gpr_we_     <= READ;
            r_gpr_wr_addr <= '0;
            r_gpr_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gpr_we_ <= w_wr_fire ? WRITE : READ;
            // Address/data only move on a real write so they hold otherwise.
            if (w_wr_fire) begin
                r_gpr_wr_addr <= w_wr_addr;
                r_gpr_wr_data <= w_wr_data;
            end
            if (w_accept && bus.mem_is_load) begin
                r_rd_en     <= bus.mem_rd_en;
                r_rd_addr   <= bus.mem_rd_addr;
                r_load_type <= bus.mem_load_type;
                r_addr_lo   <= bus.mem_result[1:0];
            end
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    logic r_misaligned;

    // Only defined load types can flag, so reserved codes never trap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_load_done && w_align_valid_type && w_align_misaligned;
        end
    end

    assign load_misaligned = r_misaligned;
`else
    logic w_unused_misaligned;
    assign w_unused_misaligned = w_align_misaligned;
`endif

    assign bus.wb_stall    = w_stall;
    assign bus.gpr_we_     = r_gpr_we_;
    assign bus.gpr_wr_addr = r_gpr_wr_addr;
    assign bus.gpr_wr_data = r_gpr_wr_data;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage. Stimulus tasks push expected register-file
// writes {cycle, addr, data} into exp_q; a negedge monitor pops and compares
// every observed write and flags missing or unexpected ones. Scenario tasks
// also check stall, hold and reset behaviour inline.
// Honours WB_MISALIGN_TRAP_EN when defined.
// ----------------------------------------------------------------------------
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 32 + AW + DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_got;
    logic [EW-1:0] mon_exp;

    wb_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    wb_state_e dbg_state;
`ifdef WB_MISALIGN_TRAP_EN
    logic load_misaligned;
`endif

    wb_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .bus             (bus),
`ifdef WB_MISALIGN_TRAP_EN
        .load_misaligned (load_misaligned),
`endif
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / cycle counter / watchdog ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
                n_checks++;
                n_fail++;
                mon_exp = exp_q.pop_front();
                $display("FAIL missing_write: got no write by cycle %0d, required write in cycle %0d addr %0d data %h",
                         cyc, mon_exp[EW-1 -: 32], mon_exp[DW +: AW], mon_exp[DW-1:0]);
            end
            if (bus.gpr_we_ === 1'b0) begin
                n_checks++;
                mon_got = {cyc, bus.gpr_wr_addr, bus.gpr_wr_data};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got write cycle %0d addr %0d data %h, required no write",
                             cyc, bus.gpr_wr_addr, bus.gpr_wr_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_fail++;
                        $display("FAIL write_compare: got cycle %0d addr %0d data %h, required cycle %0d addr %0d data %h",
                                 cyc, bus.gpr_wr_addr, bus.gpr_wr_data,
                                 mon_exp[EW-1 -: 32], mon_exp[DW +: AW], mon_exp[DW-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush         = 1'b0;
        bus.mem_valid     = 1'b0;
        bus.mem_rd_en     = 1'b0;
        bus.mem_rd_addr   = '0;
        bus.mem_is_load   = 1'b0;
        bus.mem_load_type = 3'b000;
        bus.mem_result    = '0;
        bus.dbus_rvalid   = 1'b0;
        bus.dbus_rdata    = '0;
    endtask

    task automatic push_exp(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [31:0] c32;
        c32 = c;
        exp_q.push_back({c32, a, d});
    endtask

    // Presents one ALU op for a single cycle; the stage must be idle.
    task automatic issue_alu(input logic [AW-1:0] rd, input logic rd_en, input logic [DW-1:0] data);
        bus.mem_valid   = 1'b1;
        bus.mem_rd_en   = rd_en;
        bus.mem_rd_addr = rd;
        bus.mem_is_load = 1'b0;
        bus.mem_result  = data;
        if (rd_en && rd != '0) push_exp(cyc + 1, rd, data);
        tick();
        clear_inputs();
    endtask

    // Presents a load, returns rdata 'delay' cycles after acceptance, checks
    // the stall window and the trap pulse, and leaves the stage idle.
    task automatic issue_load(input string name, input logic [AW-1:0] rd, input logic rd_en,
                              input logic [2:0] lt, input logic [1:0] lo, input logic [DW-1:0] rdata,
                              input int delay, input logic exp_wr, input logic [DW-1:0] exp_d,
                              input logic exp_mis);
        int n;
        logic [DW-1:0] ea;
        n  = cyc;
        ea = $urandom();
        ea[1:0] = lo;
        bus.mem_valid     = 1'b1;
        bus.mem_rd_en     = rd_en;
        bus.mem_rd_addr   = rd;
        bus.mem_is_load   = 1'b1;
        bus.mem_load_type = lt;
        bus.mem_result    = ea;
        if (exp_wr) push_exp(n + delay + 1, rd, exp_d);
        tick();
        clear_inputs();
        for (int i = 1; i <= delay; i++) begin
            if (i == delay) begin
                bus.dbus_rvalid = 1'b1;
                bus.dbus_rdata  = rdata;
            end else begin
                bus.dbus_rdata  = $urandom();
            end
            @(negedge clk);
            n_checks++;
            if (bus.wb_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_stall: got wb_stall %b in wait cycle %0d, required 1", name, bus.wb_stall, i);
            end
            tick();
            bus.dbus_rvalid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (bus.wb_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: got wb_stall %b after completion, required 0", name, bus.wb_stall);
        end
`ifdef WB_MISALIGN_TRAP_EN
        n_checks++;
        if (load_misaligned !== exp_mis) begin
            n_fail++;
            $display("FAIL %s_trap: got load_misaligned %b, required %b", name, load_misaligned, exp_mis);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (load_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_trap_clear: got load_misaligned %b, required 0", name, load_misaligned);
        end
`endif
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks += 5;
        if (bus.wb_stall !== 1'b0)    begin n_fail++; $display("FAIL reset_stall: got %b required 0", bus.wb_stall); end
        if (bus.gpr_we_ !== 1'b1)     begin n_fail++; $display("FAIL reset_we: got %b required 1", bus.gpr_we_); end
        if (bus.gpr_wr_addr !== '0)   begin n_fail++; $display("FAIL reset_addr: got %0d required 0", bus.gpr_wr_addr); end
        if (bus.gpr_wr_data !== '0)   begin n_fail++; $display("FAIL reset_data: got %h required 0", bus.gpr_wr_data); end
        if (dbg_state !== WB_IDLE)    begin n_fail++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        issue_alu(5'd5, 1'b1, 32'h1234_5678);
        tick();
        @(negedge clk);
        n_checks += 3;
        if (bus.gpr_we_ !== 1'b1)           begin n_fail++; $display("FAIL alu_we_single: got %b required 1", bus.gpr_we_); end
        if (bus.gpr_wr_addr !== 5'd5)       begin n_fail++; $display("FAIL alu_hold_addr: got %0d required 5", bus.gpr_wr_addr); end
        if (bus.gpr_wr_data !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_hold_data: got %h required 12345678", bus.gpr_wr_data); end
        tick();
        // Consecutive ALU ops: one write per cycle.
        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] rd;
            rd = 5'($urandom_range(1, 31));
            issue_alu(rd, 1'b1, $urandom());
        end
        tick();
    endtask

    task automatic test_loads();
        issue_load("lb_lane2",  5'd1, 1'b1, LB,  2'd2, 32'h0080_0000, 3, 1'b1, 32'hFFFF_FF80, 1'b0);
        issue_load("lbu_lane2", 5'd2, 1'b1, LBU, 2'd2, 32'h0080_0000, 3, 1'b1, 32'h0000_0080, 1'b0);
        issue_load("lh_hi",     5'd3, 1'b1, LH,  2'd2, 32'h8001_0000, 1, 1'b1, 32'hFFFF_8001, 1'b0);
        issue_load("lhu_hi",    5'd4, 1'b1, LHU, 2'd2, 32'h8001_0000, $urandom_range(1, 4), 1'b1, 32'h0000_8001, 1'b0);
        issue_load("lb_lane0",  5'd5, 1'b1, LB,  2'd0, 32'hFFFF_FF7F, $urandom_range(1, 4), 1'b1, 32'h0000_007F, 1'b0);
        issue_load("lb_lane1",  5'd6, 1'b1, LB,  2'd1, 32'h0000_9A00, $urandom_range(1, 4), 1'b1, 32'hFFFF_FF9A, 1'b0);
        issue_load("lbu_lane3", 5'd7, 1'b1, LBU, 2'd3, 32'hC300_0000, $urandom_range(1, 4), 1'b1, 32'h0000_00C3, 1'b0);
        issue_load("lh_lo",     5'd8, 1'b1, LH,  2'd0, 32'h1234_7FFF, $urandom_range(1, 4), 1'b1, 32'h0000_7FFF, 1'b0);
        issue_load("lw",        5'd31, 1'b1, LW, 2'd0, 32'hDEAD_BEEF, $urandom_range(1, 4), 1'b1, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        n = cyc;
        // Load with an rvalid in its own acceptance cycle, which must be ignored.
        bus.mem_valid     = 1'b1;
        bus.mem_rd_en     = 1'b1;
        bus.mem_rd_addr   = 5'd7;
        bus.mem_is_load   = 1'b1;
        bus.mem_load_type = LW;
        bus.mem_result    = 32'h0000_1000;
        bus.dbus_rvalid   = 1'b1;
        bus.dbus_rdata    = 32'h0BAD_0BAD;
        push_exp(n + 3, 5'd7, 32'h7654_3210);
        push_exp(n + 4, 5'd9, 32'hA1B2_C3D4);
        tick();
        // ALU op waits on mem_valid throughout the stall.
        bus.dbus_rvalid = 1'b0;
        bus.mem_is_load = 1'b0;
        bus.mem_rd_addr = 5'd9;
        bus.mem_result  = 32'hA1B2_C3D4;
        @(negedge clk);
        n_checks++;
        if (bus.wb_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_same_cycle_rvalid: got wb_stall %b required 1", bus.wb_stall); end
        tick();
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = 32'h7654_3210;
        @(negedge clk);
        n_checks++;
        if (bus.wb_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got wb_stall %b required 1", bus.wb_stall); end
        tick();
        bus.dbus_rvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release: got wb_stall %b required 0", bus.wb_stall); end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_no_write();
        issue_alu(5'd12, 1'b1, 32'hCAFE_F00D);
        issue_alu(5'd0, 1'b1, 32'h1111_1111);
        issue_alu(5'd3, 1'b0, 32'h2222_2222);
        issue_load("rsv_011", 5'd4, 1'b1, 3'b011, 2'd0, 32'h3333_3333, 2, 1'b0, '0, 1'b0);
        issue_load("rsv_110", 5'd4, 1'b1, 3'b110, 2'd0, 32'h4444_4444, 1, 1'b0, '0, 1'b0);
        issue_load("rsv_111", 5'd4, 1'b1, 3'b111, 2'd0, 32'h5555_5555, 3, 1'b0, '0, 1'b0);
        issue_load("lw_x0",   5'd0, 1'b1, LW,     2'd0, 32'h6666_6666, 2, 1'b0, '0, 1'b0);
        issue_load("lw_noen", 5'd4, 1'b0, LW,     2'd0, 32'h7777_7777, 2, 1'b0, '0, 1'b0);
        // rvalid pulse while IDLE.
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = 32'h8888_8888;
        tick();
        clear_inputs();
        tick();
        @(negedge clk);
        n_checks += 3;
        if (bus.gpr_we_ !== 1'b1)              begin n_fail++; $display("FAIL nowr_we: got %b required 1", bus.gpr_we_); end
        if (bus.gpr_wr_addr !== 5'd12)         begin n_fail++; $display("FAIL nowr_hold_addr: got %0d required 12", bus.gpr_wr_addr); end
        if (bus.gpr_wr_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL nowr_hold_data: got %h required cafef00d", bus.gpr_wr_data); end
        tick();
    endtask

    task automatic test_flush();
        // Flush while waiting, then the late rvalid.
        bus.mem_valid = 1'b1; bus.mem_rd_en = 1'b1; bus.mem_rd_addr = 5'd14;
        bus.mem_is_load = 1'b1; bus.mem_load_type = LW; bus.mem_result = 32'h0000_2000;
        tick();
        clear_inputs();
        bus.flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.wb_stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %b required 1", bus.wb_stall); end
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b required 0", bus.wb_stall); end
        if (dbg_state !== WB_IDLE) begin n_fail++; $display("FAIL flush_state: got %0d required IDLE", dbg_state); end
        tick();
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = 32'h9999_9999;
        tick();
        clear_inputs();
        // Flush with an ALU op presented: not accepted.
        bus.flush = 1'b1; bus.mem_valid = 1'b1; bus.mem_rd_en = 1'b1;
        bus.mem_rd_addr = 5'd6; bus.mem_result = 32'hAAAA_AAAA;
        tick();
        clear_inputs();
        // Flush coinciding with rvalid: load dropped.
        bus.mem_valid = 1'b1; bus.mem_rd_en = 1'b1; bus.mem_rd_addr = 5'd15;
        bus.mem_is_load = 1'b1; bus.mem_load_type = LW; bus.mem_result = 32'h0000_3000;
        tick();
        clear_inputs();
        bus.flush = 1'b1; bus.dbus_rvalid = 1'b1; bus.dbus_rdata = 32'hBBBB_BBBB;
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL flush_rvalid_stall: got %b required 0", bus.wb_stall); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_load();
        issue_alu(5'd10, 1'b1, 32'hA5A5_A5A5);
        tick();
        bus.mem_valid = 1'b1; bus.mem_rd_en = 1'b1; bus.mem_rd_addr = 5'd11;
        bus.mem_is_load = 1'b1; bus.mem_load_type = LW; bus.mem_result = 32'h0000_4000;
        tick();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (bus.wb_stall !== 1'b0)  begin n_fail++; $display("FAIL rstmid_stall: got %b required 0", bus.wb_stall); end
        if (bus.gpr_we_ !== 1'b1)   begin n_fail++; $display("FAIL rstmid_we: got %b required 1", bus.gpr_we_); end
        if (bus.gpr_wr_addr !== '0) begin n_fail++; $display("FAIL rstmid_addr: got %0d required 0", bus.gpr_wr_addr); end
        if (bus.gpr_wr_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h required 0", bus.gpr_wr_data); end
        tick();
        rst_n = 1'b1;
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = 32'hCCCC_CCCC;
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got %b required 0", bus.wb_stall); end
        tick();
    endtask

    task automatic test_misalign();
`ifdef WB_MISALIGN_TRAP_EN
        issue_load("lw_mis",  5'd8,  1'b1, LW,  2'd1, 32'h89AB_CDEF, 2, 1'b0, '0, 1'b1);
        issue_load("lh_mis",  5'd8,  1'b1, LH,  2'd3, 32'h1234_F678, 1, 1'b0, '0, 1'b1);
        issue_load("lhu_mis", 5'd8,  1'b1, LHU, 2'd1, 32'h1234_F678, 3, 1'b0, '0, 1'b1);
        issue_load("lb_odd",  5'd13, 1'b1, LB,  2'd3, 32'h8100_0000, 2, 1'b1, 32'hFFFF_FF81, 1'b0);
`else
        issue_load("lw_mis",  5'd8,  1'b1, LW,  2'd1, 32'h89AB_CDEF, 2, 1'b1, 32'h89AB_CDEF, 1'b0);
        issue_load("lh_mis",  5'd9,  1'b1, LH,  2'd1, 32'h1234_F678, 1, 1'b1, 32'hFFFF_F678, 1'b0);
        issue_load("lhu_mis", 5'd10, 1'b1, LHU, 2'd3, 32'hBEEF_0000, 3, 1'b1, 32'h0000_BEEF, 1'b0);
`endif
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_back_to_back();
        test_no_write();
        test_flush();
        test_reset_mid_load();
        test_misalign();
        tick();
        tick();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
